// File: rtl/fifo_fwft_flags_pkg.sv
// fifo_fwft_flags_pkg: shared read-mode constants and parameter legality helper
package fifo_fwft_flags_pkg;
  localparam int FIFO_MODE_STD = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic bit params_ok(int add_wd, int depth, int fwft, int afull_th, int aempty_th);
    return depth >= 2 && depth <= (1 << add_wd) && (fwft == FIFO_MODE_STD || fwft == FIFO_MODE_FWFT) &&
           afull_th >= 1 && afull_th <= depth && aempty_th >= 0 && aempty_th <= depth - 1;
  endfunction
endpackage

// File: rtl/fifo_fwft_flags_if.sv
// fifo_fwft_flags_if: producer/consumer side signals of the fifo
interface fifo_fwft_flags_if #(
  parameter int add_wd = 4,
  parameter int data_wd = 32
);
  logic flush;
  logic wr;
  logic [data_wd-1:0] wr_data;
  logic rd;
  logic [data_wd-1:0] rd_data;
  logic rd_valid;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic [add_wd:0] count;
  logic overflow;
  logic underflow;
  modport master (
    output flush, wr, wr_data, rd,
    input rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input flush, wr, wr_data, rd,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_fwft_flags_wrap_ptr.sv
// fifo_wrap_ptr: pointer counting 0..depth-1 with explicit wrap and sync clear
module fifo_wrap_ptr #(
  parameter int add_wd = 4,
  parameter int depth = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [add_wd-1:0] ptr
);
  logic [add_wd-1:0] ptr_q, ptr_d;
  // next pointer: clear wins, then wrap at depth-1 (no power-of-two assumption)
  always_comb ptr_d = clr ? '0 : !inc ? ptr_q : (ptr_q == add_wd'(depth - 1)) ? '0 : ptr_q + add_wd'(1);
  // pointer register
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/fifo_fwft_flags.sv
// fifo_fwft_flags: single-clock fifo with std/fwft read, programmable flags and sticky errors
module fifo_fwft_flags
  import fifo_fwft_flags_pkg::*;
#(
  parameter int add_wd = 4,
  parameter int data_wd = 32,
  parameter int depth = 16,
  parameter int fwft = 0,
  parameter int afull_th = 12,
  parameter int aempty_th = 2
) (
  input logic clk,
  input logic rst,
  fifo_fwft_flags_if.slave bus
);
  localparam bit fwft_mode = (fwft == FIFO_MODE_FWFT);
  if (!params_ok(add_wd, depth, fwft, afull_th, aempty_th)) begin : g_bad_params
    $error("fifo_fwft_flags: illegal depth/fwft/threshold parameters");
  end
  logic [data_wd-1:0] mem [depth];
  logic [add_wd-1:0] rd_ptr, wr_ptr;
  logic [add_wd:0] count_q, count_d;
  logic ovf_q, ovf_d, udf_q, udf_d, rdv_q, rdv_d;
  logic [data_wd-1:0] rdd_q, rdd_d;
  logic full, empty, wr_acc, rd_acc;
  assign full = count_q == (add_wd+1)'(depth);
  assign empty = count_q == '0;
  assign wr_acc = bus.wr && !full && !bus.flush;
  assign rd_acc = bus.rd && !empty && !bus.flush;
  fifo_wrap_ptr #(.add_wd(add_wd), .depth(depth)) u_rd_ptr (
    .clk(clk), .rst(rst), .clr(bus.flush), .inc(rd_acc), .ptr(rd_ptr)
  );
  fifo_wrap_ptr #(.add_wd(add_wd), .depth(depth)) u_wr_ptr (
    .clk(clk), .rst(rst), .clr(bus.flush), .inc(wr_acc), .ptr(wr_ptr)
  );
  // next state: flush clears everything except rd_data; errors are sticky otherwise
  always_comb begin
    count_d = bus.flush ? '0 : count_q + {{add_wd{1'b0}}, wr_acc} - {{add_wd{1'b0}}, rd_acc};
    ovf_d = !bus.flush && (ovf_q || (bus.wr && full));
    udf_d = !bus.flush && (udf_q || (bus.rd && empty));
    rdv_d = rd_acc && !fwft_mode;
    rdd_d = (rd_acc && !fwft_mode) ? mem[rd_ptr] : rdd_q;
  end
  // control and registered read data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      rdv_q <= 1'b0;
      rdd_q <= '0;
    end else begin
      count_q <= count_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      rdv_q <= rdv_d;
      rdd_q <= rdd_d;
    end
  // storage array, intentionally not reset
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  assign bus.rd_data = fwft_mode ? mem[rd_ptr] : rdd_q;
  assign bus.rd_valid = fwft_mode ? !empty : rdv_q;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.almost_full = count_q >= (add_wd+1)'(afull_th);
  assign bus.almost_empty = count_q <= (add_wd+1)'(aempty_th);
  assign bus.count = count_q;
  assign bus.overflow = ovf_q;
  assign bus.underflow = udf_q;
endmodule

// File: tb/tb_fifo_fwft_flags.sv
// tb_fifo_fwft_flags: three fifo configurations on shared random/directed stimulus vs queue model
module tb_fifo_fwft_flags;
  typedef struct packed {
    logic [31:0] rdd;
    logic rdv, full, empty, af, ae, ovf, udf;
    logic [4:0] cnt;
  } st_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic flush = 0, wr = 0, rd = 0;
  logic [31:0] wd = '0;
  fifo_fwft_flags_if #(.add_wd(4), .data_wd(32)) b0 (), b1 (), b2 ();
  assign b0.flush = flush; assign b0.wr = wr; assign b0.wr_data = wd; assign b0.rd = rd;
  assign b1.flush = flush; assign b1.wr = wr; assign b1.wr_data = wd; assign b1.rd = rd;
  assign b2.flush = flush; assign b2.wr = wr; assign b2.wr_data = wd; assign b2.rd = rd;
  fifo_fwft_flags #(.add_wd(4), .data_wd(32), .depth(16), .fwft(0), .afull_th(12), .aempty_th(2))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  fifo_fwft_flags #(.add_wd(4), .data_wd(32), .depth(10), .fwft(0), .afull_th(8), .aempty_th(3))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  fifo_fwft_flags #(.add_wd(4), .data_wd(32), .depth(16), .fwft(1), .afull_th(12), .aempty_th(2))
    u2 (.clk(clk), .rst(rst), .bus(b2));
  st_t st [3];
  assign st[0] = {b0.rd_data, b0.rd_valid, b0.full, b0.empty, b0.almost_full, b0.almost_empty, b0.overflow, b0.underflow, b0.count};
  assign st[1] = {b1.rd_data, b1.rd_valid, b1.full, b1.empty, b1.almost_full, b1.almost_empty, b1.overflow, b1.underflow, b1.count};
  assign st[2] = {b2.rd_data, b2.rd_valid, b2.full, b2.empty, b2.almost_full, b2.almost_empty, b2.overflow, b2.underflow, b2.count};
  int dep [3] = '{16, 10, 16};
  int afl [3] = '{12, 8, 12};
  int ael [3] = '{2, 3, 2};
  bit fw [3] = '{0, 0, 1};
  logic [31:0] mq [3][$];
  bit movf [3], mudf [3], mrdv [3];
  logic [31:0] mrdd [3];
  int pass_n = 0, tot_n = 0;
  bit chk_en = 0;
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      movf[k] = 0; mudf[k] = 0; mrdv[k] = 0; mrdd[k] = '0;
    end
  endtask
  task automatic step();
    int n;
    bit wa, ra;
    logic [31:0] h;
    for (int k = 0; k < 3; k++) begin
      if (flush) begin
        mq[k].delete();
        movf[k] = 0; mudf[k] = 0; mrdv[k] = 0;
      end else begin
        n = mq[k].size();
        wa = wr && n < dep[k];
        ra = rd && n > 0;
        if (wr && !wa) movf[k] = 1;
        if (rd && !ra) mudf[k] = 1;
        mrdv[k] = 0;
        if (ra) begin
          h = mq[k].pop_front();
          if (!fw[k]) begin mrdd[k] = h; mrdv[k] = 1; end
        end
        if (wa) mq[k].push_back(wd);
      end
    end
  endtask
  task automatic cmp_all();
    int n;
    for (int k = 0; k < 3; k++) begin
      n = mq[k].size();
      chk($sformatf("u%0d count", k), 32'(st[k].cnt), 32'(n));
      chk($sformatf("u%0d full", k), 32'(st[k].full), 32'(n == dep[k]));
      chk($sformatf("u%0d empty", k), 32'(st[k].empty), 32'(n == 0));
      chk($sformatf("u%0d almost_full", k), 32'(st[k].af), 32'(n >= afl[k]));
      chk($sformatf("u%0d almost_empty", k), 32'(st[k].ae), 32'(n <= ael[k]));
      chk($sformatf("u%0d overflow", k), 32'(st[k].ovf), 32'(movf[k]));
      chk($sformatf("u%0d underflow", k), 32'(st[k].udf), 32'(mudf[k]));
      chk($sformatf("u%0d rd_valid", k), 32'(st[k].rdv), fw[k] ? 32'(n != 0) : 32'(mrdv[k]));
      if (!fw[k]) chk($sformatf("u%0d rd_data", k), st[k].rdd, mrdd[k]);
      else if (n != 0) chk($sformatf("u%0d rd_data head", k), st[k].rdd, mq[k][0]);
    end
  endtask
  always @(negedge clk) if (chk_en) cmp_all();
  task automatic cyc(bit w, logic [31:0] d, bit r, bit f);
    wr = w; wd = d; rd = r; flush = f;
    @(posedge clk);
    step();
    #1;
    wr = 0; rd = 0; flush = 0;
  endtask
  task automatic rnd(int cycles, int pw, int pr);
    for (int i = 0; i < cycles; i++)
      cyc($urandom_range(99) < pw, $urandom, $urandom_range(99) < pr, $urandom_range(99) == 0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    chk("reset count", 32'(st[0].cnt), 0);
    chk("reset empty", 32'(st[0].empty), 1);
    chk("reset full", 32'(st[0].full), 0);
    chk("reset almost_empty", 32'(st[0].ae), 1);
    chk("reset rd_data", st[0].rdd, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 32'(i), 0, 0);
      chk($sformatf("fill almost_full %0d", i), 32'(st[0].af), 32'(i >= 11));
    end
    chk("fill full", 32'(st[0].full), 1);
    chk("fill count", 32'(st[0].cnt), 16);
    cyc(1, 32'hAA, 0, 0);
    chk("17th write overflow", 32'(st[0].ovf), 1);
    chk("17th write count", 32'(st[0].cnt), 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      chk($sformatf("drain rd_valid %0d", i), 32'(st[0].rdv), 1);
      chk($sformatf("drain rd_data %0d", i), st[0].rdd, 32'(i));
    end
    cyc(0, 0, 0, 0);
    chk("rd_valid pulse ends", 32'(st[0].rdv), 0);
    chk("rd_data holds", st[0].rdd, 32'h0F);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 25; i++) begin
      cyc(1, 32'(i), 0, 0);
      cyc(0, 0, 1, 0);
      chk($sformatf("depth10 order %0d", i), st[1].rdd, 32'(i));
    end
    cyc(1, 32'h55, 0, 0);
    chk("fwft rd_valid", 32'(st[2].rdv), 1);
    chk("fwft rd_data", st[2].rdd, 32'h55);
    cyc(0, 0, 1, 0);
    chk("fwft empty after rd", 32'(st[2].empty), 1);
    cyc(1, 32'h11, 0, 0);
    cyc(1, 32'h22, 1, 0);
    chk("wr+rd count1 count", 32'(st[0].cnt), 1);
    chk("wr+rd count1 empty", 32'(st[0].empty), 0);
    chk("wr+rd count1 data", st[0].rdd, 32'h11);
    cyc(0, 0, 1, 0);
    chk("wr+rd count1 order", st[0].rdd, 32'h22);
    cyc(1, 32'h33, 1, 0);
    chk("wr+rd empty underflow", 32'(st[0].udf), 1);
    chk("wr+rd empty count", 32'(st[0].cnt), 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 32'h100 + 32'(i), 0, 0);
    cyc(1, 32'hBB, 1, 0);
    chk("wr+rd full overflow", 32'(st[0].ovf), 1);
    chk("wr+rd full count", 32'(st[0].cnt), 15);
    chk("wr+rd full data", st[0].rdd, 32'h100);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(1, 32'h200 + 32'(i), 0, 0);
    cyc(1, 32'h77, 0, 1);
    chk("flush count", 32'(st[0].cnt), 0);
    chk("flush empty", 32'(st[0].empty), 1);
    chk("flush overflow", 32'(st[0].ovf), 0);
    chk("flush underflow", 32'(st[0].udf), 0);
    cyc(1, 32'h88, 0, 0);
    chk("flush discards write", st[2].rdd, 32'h88);
    rnd(600, 70, 30);
    rnd(600, 30, 70);
    rnd(600, 50, 50);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 32'h300 + 32'(i), 1'b0, 0);
    chk("pre-reset count", 32'(st[0].cnt), 5);
    #2 rst = 1;
    #1 model_reset();
    chk("async reset count", 32'(st[0].cnt), 0);
    chk("async reset empty", 32'(st[0].empty), 1);
    chk("async reset almost_empty", 32'(st[0].ae), 1);
    chk("async reset rd_data", st[0].rdd, 0);
    chk("async reset fwft rd_valid", 32'(st[2].rdv), 0);
    @(posedge clk);
    #1 rst = 0;
    rnd(300, 60, 40);
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
